// File: rtl/sram_pkg.sv
// Shared constants, FSM state type and level helper
// for the SRAM row sequencer front end.
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.75;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    WL,
    REL
  } seq_state_t;

  function automatic real b2r(input logic b);
    return b ? VDD : VSS;
  endfunction

endpackage

// File: rtl/sram_real_drv.sv
// Maps a logic vector onto an array of real rail levels,
// bit i drives lvl[i].
module sram_real_drv
  import sram_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] bits,
  output real          lvl [0:W-1]
);

  for (genvar i = 0; i < W; i++) begin : g_lvl
    assign lvl[i] = b2r(bits[i]);
  end

endmodule

// File: rtl/sram_row_sequencer.sv
// Row access sequencer: precharge, wordline, sense/write
// pulse, release; analog controls driven as rail levels.
module sram_row_sequencer
  import sram_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3,
  localparam int AW     = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_we,
  output logic          done,
  output logic          err,
  output real           row_sel [0:AW-1],
  output real           pre_out,
  output real           sense_out,
  output real           wen_out
);

  localparam int MAXC =
    (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CW = $clog2(MAXC + 1);

  seq_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          we_q, we_n;

  logic [AW-1:0] row_q, row_n;
  logic          pre_q, pre_n;
  logic          sense_q, sense_n;
  logic          wen_q, wen_n;
  logic          done_n, err_n;

  logic accept, bad, last_n;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign bad       = (req_addr == AW'(ROWS - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = accept ? req_addr : addr_q;
    we_n    = accept ? req_we : we_q;
    unique case (state)
      IDLE: begin
        if (accept && !bad) begin
          state_n = PRE;
          cnt_n   = CW'(PRE_CYC - 1);
        end
      end
      PRE: begin
        if (cnt == '0) begin
          state_n = WL;
          cnt_n   = CW'(WL_CYC - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WL: begin
        if (cnt == '0) begin
          state_n = REL;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      REL: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output registers are loaded from the next-state decode
  // so they line up with the state they describe.
  always_comb begin
    last_n  = (state_n == WL) && (cnt_n == '0);
    pre_n   = (state_n == PRE);
    row_n   = (state_n == WL) ? addr_n + AW'(1) : '0;
    sense_n = last_n && !we_n;
    wen_n   = last_n && we_n;
    done_n  = (state_n == REL);
    err_n   = accept && bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      row_q   <= '0;
      pre_q   <= 1'b0;
      sense_q <= 1'b0;
      wen_q   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      we_q    <= we_n;
      row_q   <= row_n;
      pre_q   <= pre_n;
      sense_q <= sense_n;
      wen_q   <= wen_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  real en_lvl [0:2];

  sram_real_drv #(.W(AW)) u_row_drv (
    .bits (row_q),
    .lvl  (row_sel)
  );

  sram_real_drv #(.W(3)) u_en_drv (
    .bits ({wen_q, sense_q, pre_q}),
    .lvl  (en_lvl)
  );

  assign pre_out   = en_lvl[0];
  assign sense_out = en_lvl[1];
  assign wen_out   = en_lvl[2];

endmodule
